// File: rtl/layer_scene_ctrl_if.sv
// Bus between the frame/game event sources and the scene sequencer:
// request pulses in, layer enable mask and scene status out.
interface layer_scene_ctrl_if;
    logic       startOfFrame;
    logic       gameStart;
    logic       pauseToggle;
    logic       winEvent;
    logic       debugSw;
    logic [6:0] layerEn;
    logic       freeze;
    logic [2:0] sceneState;
    logic [7:0] frameCnt;

    modport master (
        output startOfFrame, gameStart, pauseToggle, winEvent, debugSw,
        input  layerEn, freeze, sceneState, frameCnt
    );

    modport slave (
        input  startOfFrame, gameStart, pauseToggle, winEvent, debugSw,
        output layerEn, freeze, sceneState, frameCnt
    );
endinterface

// File: rtl/layer_scene_ctrl.sv
// Frame-aligned scene sequencer driving the per-layer enable mask of the VGA mux.
// Optional macro DEBUG_LAYER_EN routes debugSw to layerEn[4] in PLAY/PAUSE/WIN_FLASH.
module layer_scene_ctrl #(
    parameter int FLASH_FRAMES  = 15,
    parameter int FLASH_TOGGLES = 6
) (
    input logic               clk,
    input logic               resetN,
    layer_scene_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_PAUSE     = 3'd2,
        S_WIN_FLASH = 3'd3,
        S_WIN_HOLD  = 3'd4
    } scene_state_t;

    localparam logic [7:0] BLINK_RELOAD = 8'(FLASH_FRAMES - 1);
    localparam logic [7:0] TOGGLE_LAST  = 8'(FLASH_TOGGLES - 1);
    localparam logic [6:0] GAME_MASK    = 7'h2F;

    scene_state_t state_reg, state_next;
    logic [7:0]   frame_cnt_reg, frame_cnt_next;
    logic [7:0]   blink_cnt_reg, blink_cnt_next;
    logic [7:0]   toggle_cnt_reg, toggle_cnt_next;
    logic         win_bit_reg, win_bit_next;
    logic         dbg_reg, dbg_next;
    logic         pend_start_reg, pend_start_next;
    logic         pend_pause_reg, pend_pause_next;
    logic         pend_win_reg, pend_win_next;
    logic [6:0]   layer_en_reg, layer_en_next;
    logic         freeze_reg, freeze_next;
    logic         want_start, want_pause, want_win, enter;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_reg      <= S_IDLE;
            frame_cnt_reg  <= 8'd0;
            blink_cnt_reg  <= 8'd0;
            toggle_cnt_reg <= 8'd0;
            win_bit_reg    <= 1'b0;
            dbg_reg        <= 1'b0;
            pend_start_reg <= 1'b0;
            pend_pause_reg <= 1'b0;
            pend_win_reg   <= 1'b0;
            layer_en_reg   <= 7'h00;
            freeze_reg     <= 1'b1;
        end else begin
            state_reg      <= state_next;
            frame_cnt_reg  <= frame_cnt_next;
            blink_cnt_reg  <= blink_cnt_next;
            toggle_cnt_reg <= toggle_cnt_next;
            win_bit_reg    <= win_bit_next;
            dbg_reg        <= dbg_next;
            pend_start_reg <= pend_start_next;
            pend_pause_reg <= pend_pause_next;
            pend_win_reg   <= pend_win_next;
            layer_en_reg   <= layer_en_next;
            freeze_reg     <= freeze_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        frame_cnt_next  = frame_cnt_reg;
        blink_cnt_next  = blink_cnt_reg;
        toggle_cnt_next = toggle_cnt_reg;
        win_bit_next    = win_bit_reg;
        dbg_next        = dbg_reg;
        enter           = 1'b0;
        // A pulse coincident with startOfFrame is treated as already pending.
        want_start      = pend_start_reg | bus.gameStart;
        want_pause      = pend_pause_reg | bus.pauseToggle;
        want_win        = pend_win_reg | bus.winEvent;
        pend_start_next = bus.startOfFrame ? 1'b0 : want_start;
        pend_pause_next = bus.startOfFrame ? 1'b0 : want_pause;
        pend_win_next   = bus.startOfFrame ? 1'b0 : want_win;

        case (state_reg)
            S_IDLE: begin
                if (bus.startOfFrame && want_start) begin
                    state_next = S_PLAY;
                    enter      = 1'b1;
                end
            end
            S_PLAY: begin
                if (bus.startOfFrame) begin
                    if (want_win) begin
                        state_next = S_WIN_FLASH;
                        enter      = 1'b1;
                    end else if (want_start) begin
                        enter      = 1'b1;
                    end else if (want_pause) begin
                        state_next = S_PAUSE;
                        enter      = 1'b1;
                    end
                end
            end
            S_PAUSE: begin
                if (bus.startOfFrame && (want_start || want_pause)) begin
                    state_next = S_PLAY;
                    enter      = 1'b1;
                end
            end
            S_WIN_FLASH: begin
                if (bus.startOfFrame) begin
                    if (blink_cnt_reg == 8'd0) begin
                        win_bit_next   = ~win_bit_reg;
                        blink_cnt_next = BLINK_RELOAD;
                        if (toggle_cnt_reg == TOGGLE_LAST) begin
                            state_next = S_WIN_HOLD;
                            enter      = 1'b1;
                        end else begin
                            toggle_cnt_next = toggle_cnt_reg + 8'd1;
                        end
                    end else begin
                        blink_cnt_next = blink_cnt_reg - 8'd1;
                    end
                end
            end
            S_WIN_HOLD: begin
                if (bus.startOfFrame && want_start) begin
                    state_next = S_PLAY;
                    enter      = 1'b1;
                end
            end
            default: begin
                // Unused codes recover without waiting for a frame boundary.
                state_next = S_IDLE;
                enter      = 1'b1;
            end
        endcase

        if (enter) begin
            frame_cnt_next = 8'd0;
        end else if (bus.startOfFrame && frame_cnt_reg != 8'hFF) begin
            frame_cnt_next = frame_cnt_reg + 8'd1;
        end

        if (enter && state_next == S_WIN_FLASH) begin
            win_bit_next    = 1'b1;
            blink_cnt_next  = BLINK_RELOAD;
            toggle_cnt_next = 8'd0;
        end

`ifdef DEBUG_LAYER_EN
        if (bus.startOfFrame) begin
            dbg_next = bus.debugSw;
        end
`else
        dbg_next = 1'b0;
`endif

        case (state_next)
            S_PLAY, S_PAUSE: layer_en_next = GAME_MASK | {2'b00, dbg_next, 4'b0000};
            S_WIN_FLASH:     layer_en_next = GAME_MASK | {win_bit_next, 1'b0, dbg_next, 4'b0000};
            S_WIN_HOLD:      layer_en_next = 7'h40;
            default:         layer_en_next = 7'h00;
        endcase
        freeze_next = (state_next != S_PLAY);
    end

    assign bus.layerEn    = layer_en_reg;
    assign bus.freeze     = freeze_reg;
    assign bus.sceneState = state_reg;
    assign bus.frameCnt   = frame_cnt_reg;
endmodule
